// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry LC-3b instruction queue between fetch and decode, presenting the head entry decoded.
// Define IRQ_BYPASS_EN so that an empty queue passes in_instr/in_tag straight to the outputs.
module ir_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [15:0]                  in_instr,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [15:0]                  out_instr,
  output logic [TAG_WIDTH-1:0]         out_tag,
  output logic [3:0]                   opcode,
  output logic [2:0]                   dest,
  output logic [2:0]                   src1,
  output logic [2:0]                   src2,
  output logic                         ir5,
  output logic                         ir11,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [15:0] mem_i [DEPTH];
  logic [TAG_WIDTH-1:0] mem_t [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic empty, byp, push, pop, wr, rd;
  logic [15:0] head_i;
  logic [TAG_WIDTH-1:0] head_t;
  always_comb begin
    empty = cnt == '0;
    in_ready = cnt != CW'(DEPTH);
`ifdef IRQ_BYPASS_EN
    byp = empty && in_valid && !flush;
`else
    byp = 1'b0;
`endif
    out_valid = !empty || byp;
    head_i = byp ? in_instr : mem_i[rptr];
    head_t = byp ? in_tag : mem_t[rptr];
    out_instr = out_valid ? head_i : '0;
    out_tag = out_valid ? head_t : '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    // a bypassed entry that is consumed immediately never touches storage
    wr = push && !(byp && out_ready);
    rd = pop && !byp;
  end
  assign opcode = out_instr[15:12];
  assign dest = out_instr[11:9];
  assign src1 = out_instr[8:6];
  assign src2 = out_instr[2:0];
  assign ir5 = out_instr[5];
  assign ir11 = out_instr[11];
  assign count = cnt;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (rd) rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk)
    if (wr && !reset && !flush) begin
      mem_i[wptr] <= in_instr;
      mem_t[wptr] <= in_tag;
    end
endmodule

// File: tb/tb_ir_queue.sv
// tb_ir_queue: scoreboard bench for ir_queue; directed scenarios followed by random traffic.
module tb_ir_queue;
  localparam int DEPTH = 4;
  localparam int TW = 16;
  localparam int CW = $clog2(DEPTH+1);
  logic clk, reset, flush, in_valid, in_ready, out_valid, out_ready, ir5, ir11;
  logic [15:0] in_instr, out_instr;
  logic [TW-1:0] in_tag, out_tag;
  logic [3:0] opcode;
  logic [2:0] dest, src1, src2;
  logic [CW-1:0] count;
  typedef struct packed {logic [15:0] i; logic [TW-1:0] t;} ent_t;
  ent_t sb[$];
  ent_t e;
  int checks = 0, failures = 0, occ = 0;
  bit eb = 0, chk_en = 0;

  ir_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_tag(out_tag), .opcode(opcode), .dest(dest), .src1(src1),
    .src2(src2), .ir5(ir5), .ir11(ir11), .count(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, x);
    end
  endtask

  // one cycle of stimulus; an accepted push is queued as the expected future output
  task automatic step(bit iv, logic [15:0] ins, logic [TW-1:0] tg, bit ordy, bit fl, bit rs);
    @(posedge clk);
    #1;
    in_valid = iv; in_instr = ins; in_tag = tg; out_ready = ordy; flush = fl; reset = rs;
    occ = sb.size();
    eb = 0;
`ifdef IRQ_BYPASS_EN
    eb = occ == 0 && iv && !fl;
`endif
    if (iv && occ < DEPTH && !fl && !rs) sb.push_back({ins, tg});
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("count", 64'(count), 64'(occ));
    chk("in_ready", 64'(in_ready), 64'(occ < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(occ > 0 || eb));
    if (out_valid && sb.size() > 0) begin
      e = sb[0];
      chk("head_instr", 64'(out_instr), 64'(e.i));
      chk("head_tag", 64'(out_tag), 64'(e.t));
      chk("fields", {opcode, dest, src1, src2, ir5, ir11},
          {e.i[15:12], e.i[11:9], e.i[8:6], e.i[2:0], e.i[5], e.i[11]});
    end else if (!out_valid)
      chk("idle_zero", 64'({out_instr, out_tag, opcode, dest, src1, src2, ir5, ir11}), 64'(0));
    if (reset || flush) sb.delete();
    else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_empty actual=%0h expected=none", out_instr);
      end else void'(sb.pop_front());
    end
  end

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; in_instr = 0; in_tag = 0;
    @(posedge clk);
    #1;
    chk_en = 1;
    step(0, 0, 0, 0, 0, 1);
    step(1, 16'h1283, 16'h3000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int n = 1; n <= 5; n++) step(1, 16'(16'h5000 + n), 16'(n), 0, 0, 0);
    for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2; n++) step(1, 16'(16'h6000 + n), 16'(n), 0, 0, 0);
    for (int n = 2; n < 12; n++) step(1, 16'(16'h6000 + n), 16'(n), 1, 0, 0);
    for (int n = 0; n < 3; n++) step(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 3; n++) step(1, 16'(16'h7000 + n), 16'(n), 0, 0, 0);
    step(1, 16'h0E05, 16'h0E05, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 2; n++) step(1, 16'(16'h8000 + n), 16'(n), 0, 0, 0);
    step(1, 16'hABCD, 16'h1234, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 16'hC1C0, 16'h4000, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 600; n++) begin
      bit rs;
      rs = $urandom_range(63) == 0;
      step(!rs && $urandom_range(2) != 0, 16'($urandom), 16'($urandom), $urandom_range(1) == 1,
           $urandom_range(31) == 0, rs);
    end
    for (int n = 0; n < DEPTH + 2; n++) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("final_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register queue: successor to the single-entry instruction register.
- Buffers up to DEPTH fetched LC-3b instruction words, each with a sideband tag (fetch PC), between fetch and decode.
- Presents the head entry as fully decoded fields, with valid/ready handshakes on both sides and a flush for redirects.
- Lets fetch run ahead of decode without stalling the front end.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- TAG_WIDTH, 16, width of sideband tag stored with each instruction.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries (branch/trap redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept; equals !full, registered-state derived only.
- in_instr  in  16  lc3b_word instruction.
- in_tag  in  TAG_WIDTH  tag for in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes head.
- out_instr  out  16  head instruction word.
- out_tag  out  TAG_WIDTH  head tag.
- opcode  out  4  lc3b_opcode, head[15:12].
- dest  out  3  head[11:9].
- src1  out  3  head[8:6].
- src2  out  3  head[2:0].
- ir5  out  1  head[5].
- ir11  out  1  head[11].
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {instr, tag}.
  - Read and write pointers of $clog2(DEPTH) bits; wrap from DEPTH-1 to 0.
  - Occupancy counter 0..DEPTH.
- Push fires when in_valid && in_ready. Pop fires when out_valid && out_ready.
- Per-cycle update, priority order:
  1. reset: pointers=0, count=0.
  2. flush: pointers=0, count=0; any push or pop that cycle is discarded.
  3. Otherwise:
     - push only: write at wptr, wptr+1, count+1.
     - pop only: rptr+1, count-1.
     - push and pop together: both pointers advance, count unchanged.
- Full/empty:
  - full = (count==DEPTH): in_ready=0, so in_valid is ignored.
  - empty = (count==0): out_valid=0, so out_ready is ignored.
  - A push and pop in the same cycle while full is impossible, because in_ready=0 when full; no combinational path from out_ready to in_ready.
- Latency: a pushed entry is visible at the outputs the cycle after the push (1-cycle, no fall-through) unless IRQ_BYPASS_EN.
- Output values:
  - When out_valid=0, out_instr, out_tag and all decoded fields are driven to 0.
  - When out_valid=1, all outputs reflect the entry at rptr.
  - Decoded fields are combinational slices of out_instr.
- Reset values: in_ready=1, out_valid=0, count=0, all data/field outputs 0.
- Reset or flush mid-stream: takes effect at the next edge; the entry under handshake that cycle is neither written nor popped.
- Ordering: strict FIFO; the tag always stays paired with its instruction.
- Storage array needs no reset; contents beyond count are don't-care and never observable.

Optional Feature:
- Macro: IRQ_BYPASS_EN.
- Defined:
  - When the queue is empty and in_valid=1, out_valid=1 in the same cycle and outputs show in_instr/in_tag combinationally.
  - If out_ready=1 that cycle, the entry is consumed without being written: count stays 0 and pointers are unchanged.
  - If out_ready=0, it is written normally.
  - flush still suppresses both the bypass and the write.
- Not defined: strict 1-cycle latency as above; no combinational path from in_* to out_*.

Test Plan:
- Reset, then push 0x1283 tag 0x3000 (ADD R1,R2,R3) with out_ready=0 -> next cycle out_valid=1, opcode=0x1, dest=1, src1=2, src2=3, ir5=0, ir11=0, out_tag=0x3000, count=1.
- DEPTH=4: push 0x5001,0x5002,0x5003,0x5004 with out_ready=0 -> count=4, in_ready=0; a 5th push of 0x5005 is ignored; then pop 4 -> outputs 0x5001..0x5004 in order, count=0, out_valid=0, outputs 0.
- Pointer wrap: keep occupancy at 2 while pushing and popping every cycle for 10 cycles, instr = 0x6000+n -> pops return 0x6000,0x6001,... contiguous, count stays 2.
- Flush: with count=3, assert flush with in_valid=1 (0x0E05) and out_ready=1 -> next cycle count=0, out_valid=0; 0x0E05 never appears.
- Reset mid-stream: with count=2, assert reset together with push -> next cycle count=0, in_ready=1, out_valid=0, outputs 0.
- IRQ_BYPASS_EN, empty: in_valid=1, in_instr=0xC1C0 (JMP R7), out_ready=1 -> same cycle out_valid=1, opcode=0xC, src1=7; next cycle count=0. Without the macro: out_valid=0 that cycle, 1 the next.
